instr_sequencer: RTL and testbench

Program sequencer for the SIMD core array. It fetches a program from a synchronous instruction memory and broadcasts one instruction per clock on the shared `instruction` bus to every core. It gates host access to core RAM through `cpen`: the host owns the RAM only while the sequencer is idle. It supports one-shot runs, frame-synchronised looping, and abort.

---
 rtl/core_pkg.sv | 22 ++
 rtl/instr_sequencer.sv | 128 ++++++++++++
 tb/tb_instr_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the SIMD core array: instruction width, the NOP
// encoding broadcast in idle slots, and the program sequencer state type.
package core_pkg;

    localparam int INSTRUCTION_WIDTH = 15;

    // bit0=0, op[5:1]=5'b10100: unused register-op code, no side effects on the core
    localparam logic [14:0] NOP_INSTR = 15'h0028;

    // Condition-suffix codes used by benches and the assembler
    localparam logic [3:0] COND_AL = 4'b1010;
    localparam logic [3:0] COND_NV = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN,
        TAIL,
        WAIT_SYNC
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Program sequencer: streams a program from synchronous instruction memory onto
// the shared instruction bus and hands core RAM to the host only while idle.
module instr_sequencer #(
    parameter int INSTRUCTION_WIDTH = core_pkg::INSTRUCTION_WIDTH,
    parameter int PC_WIDTH          = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PC_WIDTH-1:0]          program_len,
    input  logic                         loop_en,
    input  logic                         stop,
    input  logic                         frame_sync,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         cpen,
    output logic                         busy,
    output logic                         done
);
    import core_pkg::*;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_INSTR);
    localparam logic [PC_WIDTH-1:0]          PC_ONE = PC_WIDTH'(1);

    seq_state_t                   state, state_next;
    logic [PC_WIDTH-1:0]          pc, pc_next;
    logic [PC_WIDTH-1:0]          issued, issued_next;
    logic [PC_WIDTH-1:0]          len_q, len_next;
    logic                         loop_q, loop_next;
    logic                         go_q, go_next;
    logic [INSTRUCTION_WIDTH-1:0] instr_next;
    logic                         done_next;

    // A launch (start or frame_sync) is registered in go_q for one cycle
    // before FETCH, giving word0 on the bus three edges after the trigger.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        issued_next = issued;
        len_next    = len_q;
        loop_next   = loop_q;
        go_next     = 1'b0;
        instr_next  = NOP;
        done_next   = 1'b0;

        if (stop) begin
            state_next = IDLE;
            pc_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    pc_next = '0;
                    if (go_q) begin
                        state_next = FETCH;
                    end else if (start) begin
                        if (program_len == '0) begin
                            done_next = 1'b1;
                        end else begin
                            go_next   = 1'b1;
                            len_next  = program_len;
                            loop_next = loop_en;
                        end
                    end
                end
                FETCH: begin
                    pc_next     = PC_ONE;
                    issued_next = '0;
                    state_next  = RUN;
                end
                RUN: begin
                    instr_next  = imem_rdata;
                    issued_next = issued + PC_ONE;
                    // pc holds on the last issue so it never wraps past 2^PC_WIDTH-1
                    if (issued == len_q - PC_ONE) begin
                        state_next = TAIL;
                    end else begin
                        pc_next = pc + PC_ONE;
                    end
                end
                TAIL: begin
                    done_next  = 1'b1;
                    pc_next    = '0;
                    state_next = loop_q ? WAIT_SYNC : IDLE;
                end
                WAIT_SYNC: begin
                    if (go_q) begin
                        state_next = FETCH;
                    end else if (frame_sync) begin
                        go_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    pc_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            go_q        <= 1'b0;
            instruction <= NOP;
            cpen        <= 1'b1;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            go_q        <= go_next;
            instruction <= instr_next;
            cpen        <= (state_next == IDLE);
            done        <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        issued <= issued_next;
        len_q  <= len_next;
        loop_q <= loop_next;
    end

    assign imem_addr = pc;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a directed vector table, corner-case sequences and
// randomized traffic checked against a timeline model of the sequencer.
module tb_instr_sequencer;
    localparam int IW = 15;
    localparam int PW = 10;
    localparam int MEMSZ = 1 << PW;
    localparam logic [IW-1:0] NOP = 15'h0028;

    logic          clk = 1'b0;
    logic          reset, start, loop_en, stop, frame_sync;
    logic [PW-1:0] program_len, imem_addr;
    logic [IW-1:0] imem_rdata, instruction;
    logic          cpen, busy, done;
    logic [IW-1:0] mem [0:MEMSZ-1];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    instr_sequencer #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .program_len(program_len),
        .loop_en(loop_en), .stop(stop), .frame_sync(frame_sync),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
        .cpen(cpen), .busy(busy), .done(done)
    );

    // Timeline model: a pass triggered at edge T puts word k on the bus after
    // T+3+k, pulses done after T+3+L, and owns the RAM from T+1 onwards.
    int       n = 0;
    bit       m_eng = 0;
    int       m_trig = 0;
    int       m_len = 0;
    bit       m_loop = 0;
    bit       m_from_idle = 0;
    logic [IW-1:0] e_instr;
    logic [PW-1:0] e_addr;
    logic     e_cpen, e_busy, e_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, n, act, exp);
        end
    endtask

    task automatic model_step();
        int off;
        bit zdone = 0;
        bit pdone = 0;
        n++;
        if (reset) begin
            m_eng = 0;
        end else if (m_eng) begin
            off = n - m_trig;
            if (stop) m_eng = 0;
            else if (m_loop && off > 3 + m_len && frame_sync) begin
                m_trig = n;
                m_from_idle = 0;
            end else if (!m_loop && off == 3 + m_len) begin
                m_eng = 0;
                pdone = 1;
            end
        end else if (start && !stop) begin
            if (program_len == 0) zdone = 1;
            else begin
                m_eng = 1;
                m_trig = n;
                m_from_idle = 1;
                m_len = int'(program_len);
                m_loop = loop_en;
            end
        end
        e_instr = NOP; e_addr = '0; e_cpen = 1; e_busy = 0; e_done = zdone | pdone;
        if (m_eng) begin
            off = n - m_trig;
            if (off == 0) begin
                e_busy = !m_from_idle;
                e_cpen = m_from_idle;
            end else begin
                e_busy = 1;
                e_cpen = 0;
                if (off <= 2 + m_len) begin
                    e_addr = PW'((off - 1 < m_len) ? off - 1 : m_len);
                    if (off >= 3) e_instr = mem[off-3];
                end else if (off == 3 + m_len) begin
                    e_done = 1;
                end
            end
        end
    endtask

    task automatic compare(input logic [IW-1:0] xi, input logic xd, input logic xc,
                           input logic xb, input logic [PW-1:0] xa);
        check("instruction", 32'(instruction), 32'(xi));
        check("done", 32'(done), 32'(xd));
        check("cpen", 32'(cpen), 32'(xc));
        check("busy", 32'(busy), 32'(xb));
        check("imem_addr", 32'(imem_addr), 32'(xa));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare(e_instr, e_done, e_cpen, e_busy, e_addr);
    endtask

    task automatic drive(input logic s, input int len, input logic lp, input logic st, input logic fs);
        start = s; program_len = PW'(len); loop_en = lp; stop = st; frame_sync = fs;
    endtask

    typedef struct {
        logic          start;
        int            len;
        logic [IW-1:0] x_instr;
        logic          x_done, x_cpen, x_busy;
        logic [PW-1:0] x_addr;
    } vec_t;

    vec_t tbl [8];
    int   dcnt, maxa, prev_a;
    bit   wrapped, seen;

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = IW'($urandom);
        mem[0] = 15'h1234; mem[1] = 15'h2345; mem[2] = 15'h3456;
        tbl[0] = '{1'b1, 3, NOP,      1'b0, 1'b1, 1'b0, 10'd0};
        tbl[1] = '{1'b0, 0, NOP,      1'b0, 1'b0, 1'b1, 10'd0};
        tbl[2] = '{1'b0, 0, NOP,      1'b0, 1'b0, 1'b1, 10'd1};
        tbl[3] = '{1'b0, 0, 15'h1234, 1'b0, 1'b0, 1'b1, 10'd2};
        tbl[4] = '{1'b0, 0, 15'h2345, 1'b0, 1'b0, 1'b1, 10'd3};
        tbl[5] = '{1'b0, 0, 15'h3456, 1'b0, 1'b0, 1'b1, 10'd3};
        tbl[6] = '{1'b0, 0, NOP,      1'b1, 1'b1, 1'b0, 10'd0};
        tbl[7] = '{1'b0, 0, NOP,      1'b0, 1'b1, 1'b0, 10'd0};

        reset = 1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        compare(NOP, 1'b0, 1'b1, 1'b0, '0);
        reset = 0;

        // len=3 directed run, E0..E7
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].start, tbl[i].len, 0, 0, 0);
            @(posedge clk);
            model_step();
            #1;
            compare(tbl[i].x_instr, tbl[i].x_done, tbl[i].x_cpen, tbl[i].x_busy, tbl[i].x_addr);
        end

        // zero-length start
        drive(1, 0, 0, 0, 0);
        tick();
        check("zero_len_done", 32'(done), 32'd1);
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        check("zero_len_busy", 32'(busy), 32'd0);

        // looped program, three frames, one frame_sync during RUN
        drive(1, 2, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_cpen", 32'(cpen), 32'd0);
        dcnt = 0;
        for (int f = 0; f < 3; f++) begin
            drive(0, 0, 0, 0, 1);
            tick();
            drive(0, 0, 0, 0, 0);
            for (int i = 0; i < 3; i++) tick();
            if (f == 1) drive(0, 0, 0, 0, 1);
            tick();
            if (done) dcnt++;
            drive(0, 0, 0, 0, 0);
            for (int i = 0; i < 5; i++) begin
                tick();
                if (done) dcnt++;
            end
        end
        check("loop_done_count", 32'(dcnt), 32'd3);
        check("loop_still_waiting", 32'(busy), 32'd1);
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();

        // stop two cycles into a len=8 run, then re-run from word 0
        drive(1, 8, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        compare(NOP, 1'b0, 1'b1, 1'b0, '0);
        drive(1, 8, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) tick();

        // start ignored while busy, then reset mid-run
        drive(1, 5, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        drive(1, 2, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        reset = 1;
        tick();
        compare(NOP, 1'b0, 1'b1, 1'b0, '0);
        reset = 0;
        tick();

        // start together with stop in IDLE
        drive(1, 4, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        check("start_stop_busy", 32'(busy), 32'd0);

        // maximum-length program
        for (int i = 0; i < MEMSZ; i++) mem[i] = IW'(i * 7 + 3);
        drive(1, MEMSZ - 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        dcnt = 0; maxa = 0; prev_a = 0; wrapped = 0; seen = 0;
        for (int i = 0; i < MEMSZ + 20 && !seen; i++) begin
            tick();
            if (busy && int'(imem_addr) < prev_a) wrapped = 1;
            if (busy) prev_a = int'(imem_addr);
            if (int'(imem_addr) > maxa) maxa = int'(imem_addr);
            if (done) begin dcnt++; seen = 1; end
        end
        check("maxlen_finished", 32'(seen), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("maxlen_max_addr", 32'(maxa), 32'(MEMSZ - 1));
        check("maxlen_no_wrap", 32'(wrapped), 32'd0);
        check("maxlen_done_once", 32'(dcnt), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)),
                  logic'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 5) == 0));
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
